// File: rtl/avli2c_pkg.sv
// Shared types and constants for the avli2c write sequencer.
package avli2c_pkg;

    localparam int unsigned BYTE_W             = 8;
    localparam int unsigned POLL_CNT_W         = 8;
    localparam int unsigned POLL_LIMIT_DEFAULT = 255;
    localparam logic        I2C_WRITE_BIT      = 1'b0;

    // Transaction and ACK-poll states; command states use issue/wait phases.
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        START   = 4'd1,
        CTRL    = 4'd2,
        NEXT    = 4'd3,
        DATA    = 4'd4,
        STOP    = 4'd5,
        P_START = 4'd6,
        P_CTRL  = 4'd7,
        P_STOP  = 4'd8,
        ABORT   = 4'd9
    } state_e;

    typedef enum logic {
        PH_ISSUE = 1'b0,
        PH_WAIT  = 1'b1
    } phase_e;

    // Complete register state of the sequencer, outputs included.
    typedef struct packed {
        state_e                  state;
        phase_e                  phase;
        logic [POLL_CNT_W-1:0]   poll_cnt;
        logic                    success;
        logic [BYTE_W-1:0]       data_byte;
        logic                    read_data;
        logic                    clear;
        logic                    cmd_start;
        logic                    cmd_write;
        logic                    cmd_stop;
        logic [BYTE_W-1:0]       cmd_data;
        logic                    busy;
        logic                    error;
    } regs_t;

    localparam regs_t REGS_RESET = '{
        state:     IDLE,
        phase:     PH_ISSUE,
        poll_cnt:  '0,
        success:   1'b0,
        data_byte: '0,
        read_data: 1'b0,
        clear:     1'b0,
        cmd_start: 1'b0,
        cmd_write: 1'b0,
        cmd_stop:  1'b0,
        cmd_data:  '0,
        busy:      1'b0,
        error:     1'b0
    };

    // Control byte for a write to the given 7-bit slave address.
    function automatic logic [BYTE_W-1:0] ctrl_byte(input logic [6:0] addr);
        return {addr, I2C_WRITE_BIT};
    endfunction

endpackage

// File: rtl/avli2c_write_sequencer.sv
// Drains the avli2c address/data buffer into i2c_master byte commands,
// then ACK-polls the EEPROM until its internal write cycle finishes.
module avli2c_write_sequencer
    import avli2c_pkg::*;
#(
    parameter logic [6:0]  DEVICE_ADDR = 7'h50,
    parameter int unsigned POLL_LIMIT  = POLL_LIMIT_DEFAULT
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              data_available_i,
    input  logic [BYTE_W-1:0] data_i,
    output logic              read_data_o,
    output logic              clear_o,
    output logic              cmd_start_o,
    output logic              cmd_write_o,
    output logic              cmd_stop_o,
    output logic [BYTE_W-1:0] cmd_data_o,
    input  logic              master_busy_i,
    input  logic              done_i,
    input  logic              nack_i,
    output logic              busy_o,
    output logic              error_o
);

    localparam logic [BYTE_W-1:0]     CTRL_BYTE = ctrl_byte(DEVICE_ADDR);
    localparam logic [POLL_CNT_W-1:0] POLL_MAX  = POLL_CNT_W'(POLL_LIMIT);

    regs_t regs_q;
    regs_t regs_d;
    logic  can_issue;
    logic  wait_done;

    // Issue only when the master can take a command; done only counts while waiting.
    assign can_issue = (regs_q.phase == PH_ISSUE) && !master_busy_i;
    assign wait_done = (regs_q.phase == PH_WAIT) && done_i;

    // Next-state and registered-output computation.
    always_comb begin
        regs_d           = regs_q;
        regs_d.read_data = 1'b0;
        regs_d.clear     = 1'b0;
        regs_d.cmd_start = 1'b0;
        regs_d.cmd_write = 1'b0;
        regs_d.cmd_stop  = 1'b0;

        // The popped byte is only valid while the pop strobe is high.
        if (regs_q.read_data) begin
            regs_d.data_byte = data_i;
        end

        unique case (regs_q.state)
            IDLE: begin
                if (data_available_i) begin
                    regs_d.state = START;
                    regs_d.phase = PH_ISSUE;
                    regs_d.error = 1'b0;
                end
            end
            START: begin
                if (can_issue) begin
                    regs_d.cmd_start = 1'b1;
                    regs_d.phase     = PH_WAIT;
                end else if (wait_done) begin
                    regs_d.state = CTRL;
                    regs_d.phase = PH_ISSUE;
                end
            end
            CTRL: begin
                if (can_issue) begin
                    regs_d.cmd_write = 1'b1;
                    regs_d.cmd_data  = CTRL_BYTE;
                    regs_d.phase     = PH_WAIT;
                end else if (wait_done) begin
                    regs_d.state = nack_i ? ABORT : NEXT;
                    regs_d.phase = PH_ISSUE;
                end
            end
            NEXT: begin
                regs_d.phase = PH_ISSUE;
                if (data_available_i) begin
                    regs_d.read_data = 1'b1;
                    regs_d.state     = DATA;
                end else begin
                    regs_d.state = STOP;
                end
            end
            DATA: begin
                if (can_issue) begin
                    regs_d.cmd_write = 1'b1;
                    regs_d.cmd_data  = regs_q.read_data ? data_i : regs_q.data_byte;
                    regs_d.phase     = PH_WAIT;
                end else if (wait_done) begin
                    regs_d.state = nack_i ? ABORT : NEXT;
                    regs_d.phase = PH_ISSUE;
                end
            end
            STOP: begin
                if (can_issue) begin
                    regs_d.cmd_stop = 1'b1;
                    regs_d.phase    = PH_WAIT;
                end else if (wait_done) begin
                    regs_d.state    = P_START;
                    regs_d.phase    = PH_ISSUE;
                    regs_d.poll_cnt = '0;
                    regs_d.success  = 1'b0;
                end
            end
            P_START: begin
                if (can_issue) begin
                    regs_d.cmd_start = 1'b1;
                    regs_d.phase     = PH_WAIT;
                end else if (wait_done) begin
                    regs_d.state = P_CTRL;
                    regs_d.phase = PH_ISSUE;
                end
            end
            P_CTRL: begin
                if (can_issue) begin
                    regs_d.cmd_write = 1'b1;
                    regs_d.cmd_data  = CTRL_BYTE;
                    regs_d.phase     = PH_WAIT;
                end else if (wait_done) begin
                    if (nack_i) begin
                        if (regs_q.poll_cnt != '1) begin
                            regs_d.poll_cnt = POLL_CNT_W'(regs_q.poll_cnt + 1'b1);
                        end
                    end else begin
                        regs_d.success = 1'b1;
                    end
                    regs_d.state = P_STOP;
                    regs_d.phase = PH_ISSUE;
                end
            end
            P_STOP: begin
                if (can_issue) begin
                    regs_d.cmd_stop = 1'b1;
                    regs_d.phase    = PH_WAIT;
                end else if (wait_done) begin
                    regs_d.phase = PH_ISSUE;
                    if (regs_q.success) begin
                        regs_d.state = IDLE;
                    end else if (regs_q.poll_cnt == POLL_MAX) begin
                        regs_d.error = 1'b1;
                        regs_d.state = IDLE;
                    end else begin
                        regs_d.state = P_START;
                    end
                end
            end
            ABORT: begin
                if (can_issue) begin
                    regs_d.cmd_stop = 1'b1;
                    regs_d.clear    = 1'b1;
                    regs_d.error    = 1'b1;
                    regs_d.phase    = PH_WAIT;
                end else if (wait_done) begin
                    regs_d.state = IDLE;
                    regs_d.phase = PH_ISSUE;
                end
            end
            default: begin
                regs_d.state = IDLE;
                regs_d.phase = PH_ISSUE;
            end
        endcase

        regs_d.busy = (regs_d.state != IDLE);
    end

    // State register; reset drops every output at once.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            regs_q <= REGS_RESET;
        end else begin
            regs_q <= regs_d;
        end
    end

    assign read_data_o = regs_q.read_data;
    assign clear_o     = regs_q.clear;
    assign cmd_start_o = regs_q.cmd_start;
    assign cmd_write_o = regs_q.cmd_write;
    assign cmd_stop_o  = regs_q.cmd_stop;
    assign cmd_data_o  = regs_q.cmd_data;
    assign busy_o      = regs_q.busy;
    assign error_o     = regs_q.error;

endmodule

// File: tb/tb_avli2c_write_sequencer.sv
// Bench for avli2c_write_sequencer: buffer and i2c master/slave models,
// expected command stream derived from the transaction rules.
module tb_avli2c_write_sequencer;

    localparam logic [6:0]  TB_DEV     = 7'h50;
    localparam int unsigned TB_LIMIT   = 4;
    localparam int          CTRL_BYTE  = 8'hA0;
    localparam int          EV_START   = 256;
    localparam int          EV_STOP    = 512;
    localparam int          EV_STOPCLR = 768;
    localparam int          EV_CLR     = 1024;

    logic       clock_i;
    logic       reset_i;
    logic       data_available_i;
    logic [7:0] data_i;
    logic       read_data_o;
    logic       clear_o;
    logic       cmd_start_o;
    logic       cmd_write_o;
    logic       cmd_stop_o;
    logic [7:0] cmd_data_o;
    logic       master_busy_i;
    logic       done_i;
    logic       nack_i;
    logic       busy_o;
    logic       error_o;

    avli2c_write_sequencer #(
        .DEVICE_ADDR (TB_DEV),
        .POLL_LIMIT  (TB_LIMIT)
    ) dut (
        .clock_i          (clock_i),
        .reset_i          (reset_i),
        .data_available_i (data_available_i),
        .data_i           (data_i),
        .read_data_o      (read_data_o),
        .clear_o          (clear_o),
        .cmd_start_o      (cmd_start_o),
        .cmd_write_o      (cmd_write_o),
        .cmd_stop_o       (cmd_stop_o),
        .cmd_data_o       (cmd_data_o),
        .master_busy_i    (master_busy_i),
        .done_i           (done_i),
        .nack_i           (nack_i),
        .busy_o           (busy_o),
        .error_o          (error_o)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    int checks   = 0;
    int failures = 0;

    int         log_q[$];
    int         exp_q[$];
    logic [7:0] buf_q[$];
    logic [7:0] pay_q[$];

    bit         pending, pend_nack, hung, hang_arm, seen_stop, prev_busy, last_was_write;
    int         lat, main_idx, poll_idx, n_reads;
    logic [7:0] held_data;
    bit         pol_ctrl_nack;
    int         pol_data_nack, pol_poll_nacks;
    bit         exp_err;
    int         exp_reads;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample DUT just after the edge, then update buffer and master/slave models.
    task automatic tick();
        logic cmd, was_pending;
        @(posedge clock_i);
        #1;
        prev_busy   = master_busy_i;
        was_pending = pending;
        if (clear_o) buf_q.delete();
        if (read_data_o) begin
            check("pop_nonempty", 32'(buf_q.size() != 0), 32'd1);
            n_reads++;
            data_i = (buf_q.size() != 0) ? buf_q.pop_front() : 8'hEE;
        end else begin
            data_i = 8'($urandom);
        end
        data_available_i = (buf_q.size() != 0);
        cmd    = cmd_start_o | cmd_write_o | cmd_stop_o;
        done_i = 1'b0;
        nack_i = 1'($urandom);
        if (cmd) begin
            check("cmd_onehot", 32'(cmd_start_o) + 32'(cmd_write_o) + 32'(cmd_stop_o), 32'd1);
            check("issue_when_busy", 32'(prev_busy), 32'd0);
            check("issue_when_pending", 32'(was_pending), 32'd0);
            pending        = 1'b1;
            lat            = int'($urandom_range(0, 3));
            pend_nack      = 1'($urandom);
            last_was_write = cmd_write_o;
            if (cmd_start_o) begin
                log_q.push_back(EV_START);
            end else if (cmd_stop_o) begin
                log_q.push_back(clear_o ? EV_STOPCLR : EV_STOP);
                seen_stop = 1'b1;
            end else begin
                log_q.push_back(int'(cmd_data_o));
                held_data = cmd_data_o;
                if (!seen_stop) begin
                    pend_nack = (main_idx == 0) ? pol_ctrl_nack : (main_idx - 1 == pol_data_nack);
                    main_idx++;
                    if (hang_arm && main_idx >= 2) hung = 1'b1;
                end else begin
                    pend_nack = (poll_idx < pol_poll_nacks);
                    poll_idx++;
                end
            end
        end else if (pending) begin
            if (last_was_write) check("cmd_data_hold", 32'(cmd_data_o), 32'(held_data));
            if (!hung) begin
                if (lat == 0) begin
                    done_i  = 1'b1;
                    nack_i  = pend_nack;
                    pending = 1'b0;
                end else begin
                    lat--;
                end
            end
        end else if ($urandom_range(0, 7) == 0) begin
            done_i = 1'b1;
        end
        if (clear_o && !cmd_stop_o) log_q.push_back(EV_CLR);
        if (hung || pending) master_busy_i = 1'b1;
        else if (done_i)     master_busy_i = 1'($urandom);
        else                 master_busy_i = ($urandom_range(0, 3) == 0);
    endtask

    // Expected command stream for the payload in pay_q under the current slave policy.
    task automatic build_expected();
        int npoll;
        exp_q.delete();
        exp_q.push_back(EV_START);
        exp_q.push_back(CTRL_BYTE);
        if (pol_ctrl_nack) begin
            exp_q.push_back(EV_STOPCLR);
            exp_err   = 1'b1;
            exp_reads = 0;
            return;
        end
        for (int i = 0; i < pay_q.size(); i++) begin
            exp_q.push_back(int'(pay_q[i]));
            if (i == pol_data_nack) begin
                exp_q.push_back(EV_STOPCLR);
                exp_err   = 1'b1;
                exp_reads = i + 1;
                return;
            end
        end
        exp_q.push_back(EV_STOP);
        npoll = (pol_poll_nacks >= int'(TB_LIMIT)) ? int'(TB_LIMIT) : pol_poll_nacks + 1;
        repeat (npoll) begin
            exp_q.push_back(EV_START);
            exp_q.push_back(CTRL_BYTE);
            exp_q.push_back(EV_STOP);
        end
        exp_err   = (pol_poll_nacks >= int'(TB_LIMIT));
        exp_reads = pay_q.size();
    endtask

    task automatic start_test(input bit ctrl_nack, input int data_nack, input int poll_nacks, input bit arm);
        pol_ctrl_nack  = ctrl_nack;
        pol_data_nack  = data_nack;
        pol_poll_nacks = poll_nacks;
        hang_arm       = arm;
        hung           = 1'b0;
        log_q.delete();
        main_idx  = 0;
        poll_idx  = 0;
        seen_stop = 1'b0;
        n_reads   = 0;
        foreach (pay_q[i]) buf_q.push_back(pay_q[i]);
        data_available_i = 1'b1;
        build_expected();
    endtask

    task automatic run_check(input string name);
        int n;
        n = 0;
        while (busy_o !== 1'b1 && n < 20) begin tick(); n++; end
        check({name, ":busy_rise"}, 32'(busy_o), 32'd1);
        n = 0;
        while (busy_o !== 1'b0 && n < 5000) begin tick(); n++; end
        check({name, ":busy_fall"}, 32'(busy_o), 32'd0);
        repeat (3) tick();
        check({name, ":events"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
            check($sformatf("%s:ev%0d", name, i), 32'(log_q[i]), 32'(exp_q[i]));
        check({name, ":error"}, 32'(error_o), 32'(exp_err));
        check({name, ":pops"}, 32'(n_reads), 32'(exp_reads));
        check({name, ":buf_empty"}, 32'(buf_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        reset_i = 1'b0; data_available_i = 1'b0; data_i = 8'h00;
        master_busy_i = 1'b0; done_i = 1'b0; nack_i = 1'b0;
        pending = 1'b0; hung = 1'b0; hang_arm = 1'b0; seen_stop = 1'b0;
        last_was_write = 1'b0; held_data = 8'h00; lat = 0;
        main_idx = 0; poll_idx = 0; n_reads = 0;
        pol_ctrl_nack = 1'b0; pol_data_nack = -1; pol_poll_nacks = 0;
        repeat (3) tick();
        check("rst_flags", 32'({read_data_o, clear_o, cmd_start_o, cmd_write_o, cmd_stop_o, busy_o, error_o}), 32'd0);
        check("rst_cmd_data", 32'(cmd_data_o), 32'd0);
        #3 reset_i = 1'b1;

        pay_q = '{8'h10, 8'hA5};
        start_test(1'b0, -1, 0, 1'b0);
        run_check("basic");

        pay_q = '{8'h30, 8'h11, 8'h22, 8'h33, 8'h44};
        start_test(1'b0, -1, 0, 1'b0);
        run_check("four_bytes");

        pay_q = '{8'h10, 8'hA5};
        start_test(1'b1, -1, 0, 1'b0);
        run_check("ctrl_nack");

        pay_q = '{8'h42, 8'h5A};
        start_test(1'b0, -1, 3, 1'b0);
        run_check("poll_3_nacks");

        pay_q = '{8'h43, 8'hC3};
        start_test(1'b0, -1, 100, 1'b0);
        run_check("poll_timeout");

        pay_q = '{8'h20, 8'h01, 8'h02, 8'h03};
        start_test(1'b0, 2, 0, 1'b0);
        run_check("data_nack");

        for (int t = 0; t < 10; t++) begin
            int nd;
            int dn;
            nd = int'($urandom_range(1, 4));
            pay_q.delete();
            repeat (nd + 1) pay_q.push_back(8'($urandom));
            dn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nd)) : -1;
            start_test($urandom_range(0, 5) == 0, dn, int'($urandom_range(0, 5)), 1'b0);
            run_check($sformatf("rand%0d", t));
        end

        // Reset while the address byte write is outstanding and the master stays busy.
        pay_q = '{8'h10, 8'hA5};
        start_test(1'b0, -1, 0, 1'b1);
        n = 0;
        while (!hung && n < 200) begin tick(); n++; end
        check("hang_reached", 32'(hung), 32'd1);
        repeat (2) tick();
        #3 reset_i = 1'b0;
        #1;
        check("midrst_flags", 32'({read_data_o, clear_o, cmd_start_o, cmd_write_o, cmd_stop_o, busy_o, error_o}), 32'd0);
        check("midrst_cmd_data", 32'(cmd_data_o), 32'd0);
        hung = 1'b0; pending = 1'b0; master_busy_i = 1'b0;
        buf_q.delete(); data_available_i = 1'b0; log_q.delete();
        repeat (2) tick();
        #3 reset_i = 1'b1;
        repeat (20) tick();
        check("post_rst_busy", 32'(busy_o), 32'd0);
        check("post_rst_no_cmds", 32'(log_q.size()), 32'd0);
        check("post_rst_error", 32'(error_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
